// File: rtl/dyn_mem_d1_initiator.sv
// Requester-side controller: turns a valid/ready request stream into a dyn_mem_d1 content_en/write_en/done handshake.
// Latency: response 3 cycles after acceptance with a single-cycle memory, 1 cycle for out-of-bounds requests.
// Backpressure: rsp_ready low holds the response and blocks new requests; optional macro DYN_MEM_INIT_TIMEOUT_EN bounds WAIT.
module dyn_mem_d1_initiator #(
  parameter int WIDTH          = 32,
  parameter int SIZE           = 16,
  parameter int IDX_SIZE       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [IDX_SIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_content_en,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_write_data,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // One extra bit so SIZE == 2**IDX_SIZE is representable in the bounds compare.
  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE + 1)'(SIZE);

  state_t state_q, state_d;
  logic   wflag_q;
  logic   in_bounds;
  logic   accept;
  logic   tmo;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign in_bounds = ({1'b0, req_addr} < SIZE_W);
  assign accept    = req_valid & req_ready;

`ifdef DYN_MEM_INIT_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt_q;

  assign tmo = (tcnt_q == TO_LAST) & ~mem_done;

  // Wait-cycle counter: zero outside WAIT, counts WAIT cycles without done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else if (state_q != WAIT) begin
      tcnt_q <= '0;
    end else if (!mem_done && !tmo) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and the combinational req_ready (forced low during reset).
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid) state_d = in_bounds ? ISSUE : RESP;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_done || tmo) state_d = RESP;
      end
      RESP: begin
        req_ready = rsp_ready & reset_n;
        if (rsp_ready) begin
          if (req_valid) state_d = in_bounds ? ISSUE : RESP;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: memory strobes, latched request and response payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_content_en <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr0      <= '0;
      mem_write_data <= '0;
      wflag_q        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_write      <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      // ISSUE is only entered on an accepted in-bounds request, so req_write is the flag being latched.
      mem_content_en <= (state_d == ISSUE);
      mem_write_en   <= (state_d == ISSUE) & req_write;
      rsp_valid      <= (state_d == RESP);
      if (accept) begin
        if (in_bounds) begin
          mem_addr0      <= req_addr;
          mem_write_data <= req_wdata;
          wflag_q        <= req_write;
        end else begin
          rsp_data  <= '0;
          rsp_err   <= 1'b1;
          rsp_write <= req_write;
        end
      end
      if (state_q == WAIT && state_d == RESP) begin
        // A done arriving on the timeout cycle still wins over the timeout.
        rsp_write <= wflag_q;
        rsp_err   <= ~mem_done;
        rsp_data  <= (mem_done && !wflag_q) ? mem_read_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dyn_mem_d1_initiator.sv
// Directed bench for dyn_mem_d1_initiator with a behavioural dynamic-latency memory.
// Inputs are driven and outputs sampled on the falling clock edge.
// Memory latency, never-done mode and stray done pulses are controlled from the stimulus tasks.
module tb_dyn_mem_d1_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_write;
  logic        rsp_err;
  logic [4:0]  mem_addr0;
  logic        mem_content_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_done;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  logic [31:0] marr [0:31];
  logic [4:0]  maddr = '0;
  logic [31:0] mrd = '0;
  logic        mdone = 1'b0;
  int          mcnt = 0;
  int          mlat = 1;
  logic        never_done = 1'b0;
  logic        stray = 1'b0;
  int          en_cnt = 0;
  int          we_bad = 0;

  dyn_mem_d1_initiator #(
    .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .mem_addr0(mem_addr0), .mem_content_en(mem_content_en), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  assign mem_done      = mdone | stray;
  assign mem_read_data = mrd;

  // Memory: done arrives mlat cycles after the content_en cycle.
  always @(posedge clk) begin
    mdone <= 1'b0;
    if (mem_content_en) begin
      if (mem_write_en) marr[mem_addr0] <= mem_write_data;
      maddr <= mem_addr0;
      if (!never_done) begin
        if (mlat == 1) begin
          mdone <= 1'b1;
          mrd   <= marr[mem_addr0];
        end else begin
          mcnt <= mlat - 1;
        end
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mdone <= 1'b1;
        mrd   <= marr[maddr];
      end
    end
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (mem_content_en) en_cnt <= en_cnt + 1;
    if (mem_write_en && !mem_content_en) we_bad <= we_bad + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request and waits for its response; lat counts falling edges after acceptance.
  task automatic issue_req(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] data, output logic err,
                           output logic wr, output logic en1, output logic we1);
    int k;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k   = 1;
    en1 = mem_content_en;
    we1 = mem_write_en;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    lat  = k;
    data = rsp_data;
    err  = rsp_err;
    wr   = rsp_write;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (mem_content_en !== 1'b0) begin n_bad++; $display("FAIL rst_content_en got=%b want=0", mem_content_en); end
    n_cmp++; if (rsp_err !== 1'b0 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL rst_rsp got err=%b data=%h want 0/0", rsp_err, rsp_data); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e, w, en1, we1; int e0;
    rsp_ready = 1'b1;
    e0 = en_cnt;
    issue_req(1'b1, 5'd3, 32'hDEADBEEF, lat, d, e, w, en1, we1);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_lat got=%0d want=3", lat); end
    n_cmp++; if (d !== 32'h0 || e !== 1'b0 || w !== 1'b1) begin n_bad++; $display("FAIL wr_rsp got data=%h err=%b wr=%b want 0/0/1", d, e, w); end
    n_cmp++; if (en1 !== 1'b1 || we1 !== 1'b1) begin n_bad++; $display("FAIL wr_issue got en=%b we=%b want 1/1", en1, we1); end
    n_cmp++; if (en_cnt - e0 !== 1) begin n_bad++; $display("FAIL wr_en_cycles got=%0d want=1", en_cnt - e0); end
    e0 = en_cnt;
    issue_req(1'b0, 5'd3, 32'h0, lat, d, e, w, en1, we1);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_lat got=%0d want=3", lat); end
    n_cmp++; if (d !== 32'hDEADBEEF || e !== 1'b0 || w !== 1'b0) begin n_bad++; $display("FAIL rd_rsp got data=%h err=%b wr=%b want deadbeef/0/0", d, e, w); end
    n_cmp++; if (en1 !== 1'b1 || we1 !== 1'b0) begin n_bad++; $display("FAIL rd_issue got en=%b we=%b want 1/0", en1, we1); end
    n_cmp++; if (en_cnt - e0 !== 1) begin n_bad++; $display("FAIL rd_en_cycles got=%0d want=1", en_cnt - e0); end
  endtask

  task automatic test_oob();
    int lat; logic [31:0] d; logic e, w, en1, we1; int e0;
    e0 = en_cnt;
    issue_req(1'b0, 5'd16, 32'h0, lat, d, e, w, en1, we1);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL oob_lat got=%0d want=1", lat); end
    n_cmp++; if (d !== 32'h0 || e !== 1'b1 || w !== 1'b0) begin n_bad++; $display("FAIL oob_rsp got data=%h err=%b wr=%b want 0/1/0", d, e, w); end
    @(negedge clk);
    n_cmp++; if (en_cnt - e0 !== 0) begin n_bad++; $display("FAIL oob_no_mem got=%0d want=0", en_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e, w, en1, we1;
    int idx; int rcount;
    int rcyc [0:7]; logic [31:0] rdat [0:7]; logic rrdy [0:7];
    for (int i = 0; i < 3; i++) issue_req(1'b1, 5'(i), 32'h1000_0000 + 32'(i), lat, d, e, w, en1, we1);
    idx = 0; rcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid && rcount < 8) begin
        rcyc[rcount] = c; rdat[rcount] = rsp_data; rrdy[rcount] = req_ready;
        rcount++;
      end
      if (idx < 3) begin req_valid = 1'b1; req_write = 1'b0; req_addr = 5'(idx); end
      else req_valid = 1'b0;
      if (req_valid && req_ready) idx++;
    end
    req_valid = 1'b0;
    n_cmp++; if (rcount !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", rcount); end
    for (int i = 0; i < 3 && i < rcount; i++) begin
      n_cmp++; if (rcyc[i] !== 3 + 3 * i) begin n_bad++; $display("FAIL b2b_cycle[%0d] got=%0d want=%0d", i, rcyc[i], 3 + 3 * i); end
      n_cmp++; if (rdat[i] !== 32'h1000_0000 + 32'(i)) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, rdat[i], 32'h1000_0000 + 32'(i)); end
      n_cmp++; if (rrdy[i] !== 1'b1) begin n_bad++; $display("FAIL b2b_req_ready[%0d] got=%b want=1", i, rrdy[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d; logic e, w, en1, we1; int e0;
    rsp_ready = 1'b0;
    issue_req(1'b0, 5'd1, 32'h0, lat, d, e, w, en1, we1);
    e0 = en_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd2;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, rsp_valid); end
      n_cmp++; if (rsp_data !== 32'h1000_0001 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_payload[%0d] got data=%h err=%b want 10000001/0", i, rsp_data, rsp_err); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d] got=%b want=0", i, req_ready); end
      @(negedge clk);
    end
    n_cmp++; if (en_cnt - e0 !== 0) begin n_bad++; $display("FAIL bp_no_mem got=%0d want=0", en_cnt - e0); end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_slow_mem();
    int lat; logic [31:0] d; logic e, w, en1, we1;
    mlat = 5;
    issue_req(1'b0, 5'd2, 32'h0, lat, d, e, w, en1, we1);
    mlat = 1;
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL slow_lat got=%0d want=7", lat); end
    n_cmp++; if (d !== 32'h1000_0002 || e !== 1'b0) begin n_bad++; $display("FAIL slow_rsp got data=%h err=%b want 10000002/0", d, e); end
  endtask

  task automatic test_stray_done();
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL stray_idle[%0d] got valid=%b ready=%b want 0/1", i, rsp_valid, req_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    never_done = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL wait_hold got valid=%b ready=%b want 0/0", rsp_valid, req_ready); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst got ready=%b valid=%b want 0/0", req_ready, rsp_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    never_done = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%b want=1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_no_rsp[%0d] got=%b want=0", i, rsp_valid); end
    end
  endtask

`ifdef DYN_MEM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [31:0] d; logic e, w, en1, we1;
    never_done = 1'b1;
    issue_req(1'b0, 5'd5, 32'h0, lat, d, e, w, en1, we1);
    never_done = 1'b0;
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL tmo_lat got=%0d want=10", lat); end
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL tmo_rsp got err=%b data=%h want 1/0", e, d); end
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_late_done got=%b want=0", rsp_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_oob();
    test_back_to_back();
    test_backpressure();
    test_slow_mem();
    test_stray_done();
    test_reset_mid_wait();
`ifdef DYN_MEM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (we_bad !== 0) begin n_bad++; $display("FAIL write_en_without_en got=%0d want=0", we_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
